uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
UART transmit engine, the transmit-side counterpart of the UART receive path. It accepts one byte at a time over a valid/ready handshake and serializes it onto tx_o as a frame: start bit, 8 data bits LSB first, optional even/odd parity, then 1 or 2 stop bits. It owns the baud-rate timing and a parallel-in/serial-out shifter. It sits between the host-side byte source and the TX pad.

Parameters:
CLKS_PER_BIT, 434, clk cycles per bit period (50 MHz / 115200); legal range >= 2
PARITY_EN, 0, 1 = insert a parity bit after the data bits
PARITY_ODD, 0, parity sense when PARITY_EN=1 (0 = even, 1 = odd)
STOP_BITS, 1, number of stop bits; legal values 1 or 2

Ports:
clk  input  1  system clock; all state updates on the rising edge
nrst  input  1  synchronous active-low reset
tx_data_i  input  8  byte to send; sampled only on the accept edge
tx_valid_i  input  1  byte on tx_data_i is valid
tx_ready_o  output  1  block can accept a byte this cycle
tx_o  output  1  serial line, idle-high (mark); registered
tx_busy_o  output  1  frame in progress (state != IDLE)

Behaviour:
- Interface: one clock (clk). Reset nrst is synchronous and active-low; it is sampled only on the rising edge of clk.
- Reset (nrst=0 at a clk edge): state=IDLE, tx_o=1, baud counter=0, bit index=0, shifter=0.
- tx_ready_o = (state==IDLE) && nrst. It is combinational and therefore low throughout reset.
- Accept: a byte is accepted when tx_valid_i && tx_ready_o at a rising edge. tx_data_i is latched into the shifter on that edge. tx_valid_i is ignored when ready is low; no byte is queued.
- States: IDLE -> START -> DATA -> [PARITY if PARITY_EN] -> STOP -> IDLE.
- Latency: tx_o goes 0 in the cycle after the accept edge. No bubble cycle exists between accept and the start bit.
- Bit timing:
  - Each bit holds tx_o for exactly CLKS_PER_BIT cycles.
  - The baud counter counts 0..CLKS_PER_BIT-1 and wraps to 0 on the bit boundary, where the state or bit advances.
  - The counter is held at 0 in IDLE.
- START: tx_o=0.
- DATA:
  - tx_o = shifter[0]; the shifter shifts right by one at each bit boundary.
  - The bit index counts 0..7; leave DATA after index 7 completes.
- PARITY: tx_o = ^data, XORed with PARITY_ODD. Parity is computed on the latched byte, not on live tx_data_i.
- STOP: tx_o=1 for STOP_BITS*CLKS_PER_BIT cycles, then go to IDLE.
- Frame length: (1 + 8 + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles, measured from the first start-bit cycle to the last stop-bit cycle.
- Back-to-back: ready rises in the first IDLE cycle after the stop bit(s). If valid is held high, the next byte is accepted on that edge. Consecutive frames therefore have exactly 1 extra mark cycle between them.
- tx_data_i changing mid-frame has no effect on the frame in progress.
- Reset mid-frame: the frame aborts. tx_o=1 from the edge where nrst=0 is sampled, the state goes to IDLE, and the partial byte is discarded.
- tx_o is glitch-free: driven straight from a flop, never from combinational decode.

Decomposition:
- Shared package uart_pkg, containing:
  - typedef enum logic [2:0] uart_tx_state_t {IDLE, START, DATA, PARITY, STOP}
  - localparam UART_DATA_BITS = 8
  - localparam UART_DEFAULT_CLKS_PER_BIT = 434
  - The receiver reuses these.
- One sub-module, piso_shift_register:
  - 8-bit, with load_en / shift_en / data_i[7:0] / serial_o.
  - Synchronous active-low reset.
  - Shifts right with 0 fill; serial_o = bit 0.
- Baud counter and FSM stay inline in uart_tx.

Test Plan (CLKS_PER_BIT=4 unless noted):
- Reset idle: nrst=0 for 3 cycles, then 1 with valid=0 -> tx_o=1, tx_ready_o=1, tx_busy_o=0 on every cycle for 50 cycles.
- Single byte 0xA5, no parity, 1 stop -> tx_o sequence per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1. Frame is 40 cycles starting 1 cycle after accept; ready is low for exactly those 40 cycles.
- Parity: PARITY_EN=1, even -> 0xA5 gives parity bit 0 and 0x07 gives parity bit 1. With odd parity the values invert. Frame is 44 cycles.
- Back-to-back: valid held high with 0x55 then 0xFF, STOP_BITS=2 -> 48-cycle frames separated by exactly 1 mark cycle. Second frame data bits are all 1.
- Hold-off: tx_data_i changed and valid pulsed mid-frame -> current frame unchanged and the pulse is dropped. Only bytes accepted while ready=1 are sent.
- Reset mid-frame: nrst=0 during DATA bit 3 -> tx_o=1 at that edge, state IDLE, ready=1 after release. The next accepted byte 0x3C serializes correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, frame constants and a parity helper.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS            = 8;
  localparam int unsigned UART_DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  // Parity bit that makes the total count of ones even (odd = 0) or odd (odd = 1).
  function automatic logic uart_parity(input logic [UART_DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/piso_shift_register.sv
// Parallel-in / serial-out shifter; shifts right with zero fill, bit 0 is the serial output.
module piso_shift_register
  import uart_pkg::*;
(
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      load_en,
  input  logic                      shift_en,
  input  logic [UART_DATA_BITS-1:0] data_i,
  output logic                      serial_o
);

  logic [UART_DATA_BITS-1:0] shreg_q;

  // Load has priority over shift; both are synchronous to clk.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      shreg_q <= '0;
    end else if (load_en) begin
      shreg_q <= data_i;
    end else if (shift_en) begin
      shreg_q <= {1'b0, shreg_q[UART_DATA_BITS-1:1]};
    end
  end

  assign serial_o = shreg_q[0];

endmodule

// File: rtl/uart_tx.sv
// UART transmit engine: byte handshake in, start/data/parity/stop frame out on a registered line.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter bit          PARITY_EN    = 1'b0,
  parameter bit          PARITY_ODD   = 1'b0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       tx_o,
  output logic       tx_busy_o
);

  localparam int unsigned     CntW     = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntMax   = CntW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      LastData = 3'(UART_DATA_BITS - 1);
  localparam logic [2:0]      LastStop = 3'(STOP_BITS - 1);

  uart_tx_state_t  state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic            tx_q, tx_d;
  logic            parity_q, parity_d;
  logic            accept, bit_done, shift_en, serial;

  assign tx_ready_o = (state_q == IDLE) && nrst;
  assign tx_busy_o  = (state_q != IDLE);
  assign tx_o       = tx_q;
  assign accept     = tx_valid_i && tx_ready_o;
  assign bit_done   = (state_q != IDLE) && (cnt_q == CntMax);
  // Shift as each data bit is copied into tx_q, so serial always holds the next bit to send.
  assign shift_en   = bit_done && ((state_q == START) || (state_q == DATA));

  piso_shift_register u_shift (
    .clk      (clk),
    .nrst     (nrst),
    .load_en  (accept),
    .shift_en (shift_en),
    .data_i   (tx_data_i),
    .serial_o (serial)
  );

  // Next-state, baud counter and next line value; tx_q is loaded one edge ahead of each bit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    tx_d      = tx_q;
    parity_d  = parity_q;
    if (state_q != IDLE) begin
      cnt_d = bit_done ? '0 : cnt_q + 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        tx_d      = 1'b1;
        cnt_d     = '0;
        bit_idx_d = '0;
        if (accept) begin
          state_d  = START;
          tx_d     = 1'b0;
          // Same byte the shifter latches on this edge.
          parity_d = uart_parity(tx_data_i, PARITY_ODD);
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          tx_d    = serial;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_idx_q == LastData) begin
            bit_idx_d = '0;
            if (PARITY_EN) begin
              state_d = PARITY;
              tx_d    = parity_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = serial;
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        // bit_idx doubles as the stop-bit counter.
        if (bit_done) begin
          if (bit_idx_q == LastStop) begin
            state_d   = IDLE;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State registers with synchronous active-low reset; reset forces the line to mark.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      parity_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      parity_q  <= parity_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: four configurations driven by directed and random frames.
module tb_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       nrst;
  logic [7:0] data [4];
  logic [3:0] valid;
  logic [3:0] ready;
  logic [3:0] tx;
  logic [3:0] busy;

  // Per-instance configuration mirrored for the reference model.
  int cpb [4] = '{4, 4, 4, 3};
  int pe  [4] = '{0, 1, 1, 0};
  int po  [4] = '{0, 0, 1, 0};
  int sb  [4] = '{1, 2, 1, 2};

  int n_tests = 0;
  int n_fail  = 0;
  bit exp_bits[$];

  uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1)) u0 (
    .clk(clk), .nrst(nrst), .tx_data_i(data[0]), .tx_valid_i(valid[0]),
    .tx_ready_o(ready[0]), .tx_o(tx[0]), .tx_busy_o(busy[0])
  );
  uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(2)) u1 (
    .clk(clk), .nrst(nrst), .tx_data_i(data[1]), .tx_valid_i(valid[1]),
    .tx_ready_o(ready[1]), .tx_o(tx[1]), .tx_busy_o(busy[1])
  );
  uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(1)) u2 (
    .clk(clk), .nrst(nrst), .tx_data_i(data[2]), .tx_valid_i(valid[2]),
    .tx_ready_o(ready[2]), .tx_o(tx[2]), .tx_busy_o(busy[2])
  );
  uart_tx #(.CLKS_PER_BIT(3), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(2)) u3 (
    .clk(clk), .nrst(nrst), .tx_data_i(data[3]), .tx_valid_i(valid[3]),
    .tx_ready_o(ready[3]), .tx_o(tx[3]), .tx_busy_o(busy[3])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame as a list of bit values: start, data LSB first, optional parity, stop bits.
  function automatic void model_frame(input int k, input logic [7:0] b);
    int ones;
    ones = 0;
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      exp_bits.push_back(b[i]);
      ones += int'(b[i]);
    end
    if (pe[k] != 0) exp_bits.push_back(bit'((ones % 2) ^ po[k]));
    for (int i = 0; i < sb[k]; i++) exp_bits.push_back(1'b1);
  endfunction

  // Offer byte b to instance k, then check every cycle of the frame and the following mark cycle.
  task automatic run_frame(input int k, input logic [7:0] b, input bit keep_valid,
                           input logic [7:0] next_b, input bit pulse_mid, input string name);
    int len;
    check({name, " ready_pre"}, 32'(ready[k]), 32'd1);
    data[k]  = b;
    valid[k] = 1'b1;
    tick();
    if (keep_valid) data[k] = next_b;
    else valid[k] = 1'b0;
    model_frame(k, b);
    len = exp_bits.size() * cpb[k];
    for (int i = 0; i < len; i++) begin
      check($sformatf("%s tx c%0d", name, i), 32'(tx[k]), 32'(exp_bits[i / cpb[k]]));
      check($sformatf("%s ready c%0d", name, i), 32'(ready[k]), 32'd0);
      check($sformatf("%s busy c%0d", name, i), 32'(busy[k]), 32'd1);
      if (pulse_mid && i == 10) begin
        data[k]  = ~b;
        valid[k] = 1'b1;
      end else if (pulse_mid && i == 11) begin
        data[k]  = 8'h00;
        valid[k] = 1'b0;
      end
      tick();
    end
    check({name, " mark_tx"}, 32'(tx[k]), 32'd1);
    check({name, " mark_ready"}, 32'(ready[k]), 32'd1);
    check({name, " mark_busy"}, 32'(busy[k]), 32'd0);
  endtask

  initial begin
    logic [7:0] cur;
    logic [7:0] nxt;
    bit         kv;

    nrst  = 1'b0;
    valid = '0;
    for (int k = 0; k < 4; k++) data[k] = 8'h00;

    // Reset: line marks, not ready, not busy.
    repeat (3) begin
      tick();
      for (int k = 0; k < 4; k++) begin
        check($sformatf("rst tx%0d", k), 32'(tx[k]), 32'd1);
        check($sformatf("rst ready%0d", k), 32'(ready[k]), 32'd0);
        check($sformatf("rst busy%0d", k), 32'(busy[k]), 32'd0);
      end
    end
    nrst = 1'b1;
    tick();
    for (int c = 0; c < 50; c++) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("idle tx%0d", k), 32'(tx[k]), 32'd1);
        check($sformatf("idle ready%0d", k), 32'(ready[k]), 32'd1);
        check($sformatf("idle busy%0d", k), 32'(busy[k]), 32'd0);
      end
      tick();
    end

    // Single byte, then even and odd parity cases.
    run_frame(0, 8'hA5, 1'b0, 8'h00, 1'b0, "a5");
    run_frame(1, 8'hA5, 1'b0, 8'h00, 1'b0, "even_a5");
    run_frame(1, 8'h07, 1'b0, 8'h00, 1'b0, "even_07");
    run_frame(2, 8'hA5, 1'b0, 8'h00, 1'b0, "odd_a5");
    run_frame(2, 8'h07, 1'b0, 8'h00, 1'b0, "odd_07");

    // Back-to-back with valid held high; data changes mid-frame.
    run_frame(1, 8'h55, 1'b1, 8'hFF, 1'b0, "b2b_55");
    run_frame(1, 8'hFF, 1'b0, 8'h00, 1'b0, "b2b_ff");

    // Hold-off: a valid pulse during a frame must be dropped.
    run_frame(0, 8'h96, 1'b0, 8'h00, 1'b1, "holdoff");
    for (int c = 0; c < 8; c++) begin
      check("holdoff_drop tx", 32'(tx[0]), 32'd1);
      check("holdoff_drop busy", 32'(busy[0]), 32'd0);
      tick();
    end

    // Reset during data bit 3.
    data[0]  = 8'hC3;
    valid[0] = 1'b1;
    tick();
    valid[0] = 1'b0;
    repeat (17) tick();
    check("abort pre_tx", 32'(tx[0]), 32'd0);
    check("abort pre_busy", 32'(busy[0]), 32'd1);
    nrst = 1'b0;
    tick();
    check("abort tx", 32'(tx[0]), 32'd1);
    check("abort busy", 32'(busy[0]), 32'd0);
    check("abort ready_in_rst", 32'(ready[0]), 32'd0);
    nrst = 1'b1;
    #1;
    check("abort ready_release", 32'(ready[0]), 32'd1);
    tick();
    run_frame(0, 8'h3C, 1'b0, 8'h00, 1'b0, "after_abort_3c");

    // Random bytes with random back-to-back or gapped spacing on every configuration.
    for (int k = 0; k < 4; k++) begin
      cur = 8'($urandom);
      for (int n = 0; n < 6; n++) begin
        nxt = 8'($urandom);
        kv  = 1'($urandom_range(0, 1));
        run_frame(k, cur, kv, nxt, 1'b0, $sformatf("rnd%0d_%0d", k, n));
        if (!kv) repeat (int'($urandom_range(0, 3))) tick();
        cur = nxt;
      end
      valid[k] = 1'b0;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
